// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags: feeds rename at dispatch and
// reclaims tags freed by commit (old safe mapping) and revert (undone speculation).
module phys_reg_free_list #(
   parameter int NUM_ARCH_REGS = 32,
   parameter int NUM_PHYS_REGS = 64,
   parameter int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS,
   localparam int TAG_W        = $clog2(NUM_PHYS_REGS),
   localparam int PTR_W        = $clog2(DEPTH),
   localparam int CNT_W        = PTR_W + 1
) (
   input  logic             CLK,
   input  logic             nRST,
   output logic             dequeue_valid,
   output logic [TAG_W-1:0] dequeue_phys_reg_tag,
   input  logic             dequeue_ready,
   input  logic             commit_free_valid,
   input  logic [TAG_W-1:0] commit_free_phys_reg_tag,
   input  logic             revert_free_valid,
   input  logic [TAG_W-1:0] revert_free_phys_reg_tag,
   output logic [CNT_W-1:0] free_list_count,
   output logic             free_list_empty
);

   logic [TAG_W-1:0] r_entry [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic             w_empty;
   logic             w_deq_fire;
   logic             w_rev_acc;
   logic             w_com_acc;
   logic [1:0]       w_n_acc;
   logic [PTR_W-1:0] w_com_addr;
   logic [CNT_W:0]   w_sum;
   logic             w_overflow;

   assign w_empty    = (r_count == '0);
   assign w_deq_fire = ~w_empty & dequeue_ready;

   // Tag 0 is the hard-wired zero register and never re-enters the list.
   assign w_rev_acc  = revert_free_valid & (revert_free_phys_reg_tag != '0);
   assign w_com_acc  = commit_free_valid & (commit_free_phys_reg_tag != '0);
   assign w_n_acc    = {1'b0, w_rev_acc} + {1'b0, w_com_acc};

   // Revert lands first; commit takes the following slot when both arrive.
   assign w_com_addr = r_tail + PTR_W'(w_rev_acc);

   assign w_sum      = {1'b0, r_count} + (CNT_W+1)'(w_n_acc) - (CNT_W+1)'(w_deq_fire);
   assign w_overflow = (w_sum > (CNT_W+1)'(DEPTH));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= CNT_W'(DEPTH);
         for (int i = 0; i < DEPTH; i++) begin
            r_entry[i] <= TAG_W'(NUM_ARCH_REGS + i);
         end
      end else begin
         assert (!w_overflow)
            else $error("free list overflow: count=%0d revert_tag=%0d commit_tag=%0d",
                        r_count, revert_free_phys_reg_tag, commit_free_phys_reg_tag);
         if (w_deq_fire) begin
            r_head <= r_head + PTR_W'(1);
         end
         if (!w_overflow) begin
            if (w_rev_acc) begin
               r_entry[r_tail] <= revert_free_phys_reg_tag;
            end
            if (w_com_acc) begin
               r_entry[w_com_addr] <= commit_free_phys_reg_tag;
            end
            r_tail  <= r_tail + PTR_W'(w_n_acc);
            r_count <= w_sum[CNT_W-1:0];
         end else begin
            // Writes are dropped on an overflow and the count pins at full.
            r_count <= CNT_W'(DEPTH);
         end
      end
   end

   assign dequeue_phys_reg_tag = r_entry[r_head];
   assign free_list_count      = r_count;
   assign free_list_empty      = w_empty;
   assign dequeue_valid        = ~w_empty;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed scenarios plus randomized traffic
// checked against a queue model of free tags and a pool of tags held by rename.
module tb_phys_reg_free_list;

   logic       CLK;
   logic       nRST;
   logic       dequeue_valid;
   logic [5:0] dequeue_phys_reg_tag;
   logic       dequeue_ready;
   logic       commit_free_valid;
   logic [5:0] commit_free_phys_reg_tag;
   logic       revert_free_valid;
   logic [5:0] revert_free_phys_reg_tag;
   logic [5:0] free_list_count;
   logic       free_list_empty;

   int checks = 0;
   int errors = 0;
   int model[$];
   int held[$];

   phys_reg_free_list dut (
      .CLK                      (CLK),
      .nRST                     (nRST),
      .dequeue_valid            (dequeue_valid),
      .dequeue_phys_reg_tag     (dequeue_phys_reg_tag),
      .dequeue_ready            (dequeue_ready),
      .commit_free_valid        (commit_free_valid),
      .commit_free_phys_reg_tag (commit_free_phys_reg_tag),
      .revert_free_valid        (revert_free_valid),
      .revert_free_phys_reg_tag (revert_free_phys_reg_tag),
      .free_list_count          (free_list_count),
      .free_list_empty          (free_list_empty)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
         end
   endtask

   task automatic model_reset();
      model.delete();
      held.delete();
      for (int i = 0; i < 32; i++) model.push_back(32 + i);
   endtask

   task automatic push_free(input int tag);
      int found;
      found = 0;
      foreach (model[k]) if (model[k] == tag) found = 1;
      chk("dup_free", found, 0);
      model.push_back(tag);
   endtask

   task automatic check_outputs(input string where);
      int n;
      n = model.size();
      chk({where, "_valid"}, int'(dequeue_valid), int'(n != 0));
      chk({where, "_count"}, int'(free_list_count), n);
      chk({where, "_empty"}, int'(free_list_empty), int'(n == 0));
      if (n != 0) begin
         chk({where, "_tag"}, int'(dequeue_phys_reg_tag), model[0]);
         chk({where, "_nonzero"}, int'(dequeue_phys_reg_tag != 6'd0), 1);
      end
   endtask

   // Called at a falling edge: drive, check pre-edge state, clock, update model.
   task automatic cycle(input logic rdy, input logic cv, input logic [5:0] ct,
                        input logic rv, input logic [5:0] rt);
      logic fire;
      dequeue_ready            = rdy;
      commit_free_valid        = cv;
      commit_free_phys_reg_tag = ct;
      revert_free_valid        = rv;
      revert_free_phys_reg_tag = rt;
      check_outputs("cyc");
      fire = rdy && (model.size() != 0);
      @(posedge CLK);
      if (fire) held.push_back(model.pop_front());
      if (rv && rt != 6'd0) push_free(int'(rt));
      if (cv && ct != 6'd0) push_free(int'(ct));
      @(negedge CLK);
   endtask

   task automatic do_reset();
      dequeue_ready            = 1'b0;
      commit_free_valid        = 1'b0;
      commit_free_phys_reg_tag = 6'd0;
      revert_free_valid        = 1'b0;
      revert_free_phys_reg_tag = 6'd0;
      nRST = 1'b0;
      #2;
      model_reset();
      check_outputs("rst");
      #1 nRST = 1'b1;
      @(negedge CLK);
   endtask

   initial begin
      logic       rdy, cv, rv;
      logic [5:0] ct, rt;
      int         idx;

      nRST = 1'b0;
      dequeue_ready            = 1'b0;
      commit_free_valid        = 1'b0;
      commit_free_phys_reg_tag = 6'd0;
      revert_free_valid        = 1'b0;
      revert_free_phys_reg_tag = 6'd0;
      @(negedge CLK);
      do_reset();

      // Drain all 32 reset tags; the 33rd ready must be ignored.
      for (int i = 0; i < 33; i++) cycle(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      chk("drain_count", int'(free_list_count), 0);

      // Enqueue into empty: visible one cycle later, not bypassed.
      cycle(1'b0, 1'b1, 6'd5, 1'b0, 6'd0);
      chk("nobypass_tag", int'(dequeue_phys_reg_tag), 5);

      // Build count=10, then dual enqueue revert 40 / commit 7.
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 6'(10 + i), 1'b0, 6'd0);
      chk("pre_dual_count", int'(free_list_count), 10);
      cycle(1'b0, 1'b1, 6'd7, 1'b1, 6'd40);
      chk("dual_count", int'(free_list_count), 12);
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);

      // Fill to 31, then dequeue plus dual enqueue reaches exactly full.
      for (int k = 0; k < 15; k++) cycle(1'b0, 1'b1, 6'(33 + 2 * k), 1'b1, 6'(32 + 2 * k));
      cycle(1'b0, 1'b1, 6'd62, 1'b0, 6'd0);
      chk("pre_full_count", int'(free_list_count), 31);
      cycle(1'b1, 1'b1, 6'd63, 1'b1, 6'd1);
      chk("full_count", int'(free_list_count), 32);
      chk("full_head", int'(dequeue_phys_reg_tag), 33);
      for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);

      // Commit tag 0 is dropped while revert tag 9 is kept.
      cycle(1'b0, 1'b1, 6'd0, 1'b1, 6'd9);
      chk("zero_drop_count", int'(free_list_count), 1);
      cycle(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      cycle(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);

      // Randomized traffic across pointer wrap, with a reset pulse mid-run.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         if (i == 50) begin
            do_reset();
            chk("midrst_count", int'(free_list_count), 32);
            chk("midrst_head", int'(dequeue_phys_reg_tag), 32);
         end
         rdy = 1'($urandom_range(0, 1));
         rv = 1'b0; rt = 6'd0; cv = 1'b0; ct = 6'd0;
         if (held.size() != 0 && $urandom_range(0, 2) != 0) begin
            idx = $urandom_range(0, held.size() - 1);
            rt = 6'(held[idx]);
            held.delete(idx);
            rv = 1'b1;
         end
         if ($urandom_range(0, 7) == 0) begin
            cv = 1'b1;
            ct = 6'd0;
         end else if (held.size() != 0 && $urandom_range(0, 2) != 0) begin
            idx = $urandom_range(0, held.size() - 1);
            ct = 6'(held[idx]);
            held.delete(idx);
            cv = 1'b1;
         end
         cycle(rdy, cv, ct, rv, rt);
      end
      check_outputs("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
Circular FIFO of free physical register tags. It feeds rename_dest_phys_reg_tag to the physical register map table at dispatch/rename. It reclaims tags from two sources: commit, which frees the old safe mapping, and revert, which frees the undone speculated mapping. It sits in the core between dispatch control and the map table, and is instantiated once per core.

Parameters:
NUM_ARCH_REGS, 32, architectural registers; tags 0..NUM_ARCH_REGS-1 are mapped at reset and are not in the list.
NUM_PHYS_REGS, 64, total physical registers; tag width = clog2(NUM_PHYS_REGS) = 6 (phys_reg_tag_t).
DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS = 32, FIFO entries; must be a power of 2.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
dequeue_valid  out  1  head entry holds a free tag (count != 0).
dequeue_phys_reg_tag  out  6  tag at head; feeds map table rename_dest_phys_reg_tag.
dequeue_ready  in  1  rename consumes the head tag this cycle.
commit_free_valid  in  1  commit frees a tag.
commit_free_phys_reg_tag  in  6  old safe phys tag of the committing instruction.
revert_free_valid  in  1  revert frees a tag.
revert_free_phys_reg_tag  in  6  speculated phys tag being undone.
free_list_count  out  6  number of free tags held (0..DEPTH).
free_list_empty  out  1  count == 0.

Behaviour:
- Reset (asynchronous, nRST low): head_ptr=0, tail_ptr=0, count=DEPTH, entry[i]=NUM_ARCH_REGS+i. Outputs immediately become dequeue_valid=1, dequeue_phys_reg_tag=32, free_list_count=32, free_list_empty=0. Reset asserted mid-operation discards all state.
- State: DEPTH x 6-bit array; head_ptr and tail_ptr of clog2(DEPTH) bits; count of clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH through natural overflow.
- Outputs are purely registered state:
  - dequeue_phys_reg_tag = entry[head_ptr], driven even when dequeue_valid=0.
  - dequeue_valid = ~free_list_empty.
- Dequeue: dequeue fires when dequeue_valid & dequeue_ready. On fire, head_ptr+1 and count-1 at the next edge. dequeue_ready while empty is ignored, with no state change.
- Enqueue: a request is accepted when its valid is high and its tag != 0. Tag 0 is the hard-wired zero register and is silently dropped.
  - Both requests accepted in one cycle: revert tag written at tail_ptr, commit tag at tail_ptr+1, tail_ptr+2.
  - Only one accepted: written at tail_ptr, tail_ptr+1.
- Count update each cycle: count_next = count + accepted_enqueues - dequeue_fire.
- No bypass: a tag enqueued in cycle N is dequeueable at the earliest in cycle N+1, including when the list is empty in cycle N.
- Simultaneous dequeue and enqueue(s): all take effect in the same edge; the head read uses the pre-edge entry.
- Overflow: the system guarantees count + accepted_enqueues - dequeue_fire <= DEPTH. A violation raises an assertion with a $display of count and tags. The write is then dropped, and count saturates at DEPTH.
- Duplicate free: a tag already present in the list is not checked in RTL. The bench scoreboard flags it.
- Single cycle; no stall state. Dispatch must stall externally on free_list_empty.

Test Plan:
1. Reset, then dequeue_ready=1 held for 33 cycles:
   - tags 32,33,...,63 appear in order, one per cycle.
   - After 32 fires: free_list_empty=1, dequeue_valid=0, count=0.
   - The 33rd ready is ignored, with no pointer movement.
2. From empty, commit_free_valid=1 with tag 5 in cycle N:
   - cycle N: dequeue_valid=0.
   - cycle N+1: dequeue_valid=1, tag=5, count=1.
3. Dual enqueue in one cycle (revert tag 40, commit tag 7) with count=10:
   - count becomes 12.
   - Subsequent dequeues return 40 before 7, after the 10 older entries.
4. Dequeue plus dual enqueue in one cycle at count=31:
   - count becomes 32, with no overflow assertion.
   - Head advances; the new tags land at the old tail and tail+1.
5. commit_free_valid with tag 0 and revert_free_valid with tag 9 in the same cycle:
   - only 9 is enqueued, count+1.
   - Tag 0 never appears on dequeue_phys_reg_tag.
6. Wrap-around: 100 random cycles of mixed dequeue/enqueue, with nRST pulsed low mid-run:
   - FIFO order matches the scoreboard model across pointer wrap.
   - After reset, state returns to count=32 and head tag=32.
